// File: rtl/irq_priority_router_if.sv
// Handshake/bus bundle between interrupt sources and the priority router.
// The router takes the slave modport; the service side takes master.
interface irq_priority_router_if #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 8
);
   localparam int ID_W = $clog2(N_CH);

   logic [N_CH-1:0]        irq_i;
   logic [N_CH-1:0]        mask_i;
   logic [N_CH*DATA_W-1:0] data_i;
   logic                   ready_i;
   logic                   valid_o;
   logic [N_CH-1:0]        ch_o;
   logic [ID_W-1:0]        id_o;
   logic [DATA_W-1:0]      data_o;
   logic                   multi_o;
   logic [N_CH-1:0]        pending_o;
   logic [N_CH-1:0]        overrun_o;

   modport master (
      output irq_i, mask_i, data_i, ready_i,
      input  valid_o, ch_o, id_o, data_o, multi_o, pending_o, overrun_o
   );

   modport slave (
      input  irq_i, mask_i, data_i, ready_i,
      output valid_o, ch_o, id_o, data_o, multi_o, pending_o, overrun_o
   );
endinterface

// File: rtl/irq_priority_router.sv
// Registered interrupt router: edge-latched pending bits, masking, fixed or
// round-robin arbitration, one grant at a time on a valid/ready handshake.
module irq_priority_router #(
   parameter int N_CH    = 4,
   parameter int DATA_W  = 8,
   parameter int RR_MODE = 0,
   localparam int ID_W   = $clog2(N_CH)
) (
   input logic                 clk_i,
   input logic                 rst_i,
   irq_priority_router_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [N_CH-1:0]     irq_q;
   logic [N_CH-1:0]     pending_q, pending_d;
   logic [N_CH-1:0]     overrun_q, overrun_d;
   logic [N_CH-1:0]     ch_q, ch_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                multi_q, multi_d;

   logic [N_CH-1:0]     edge_v, accept_v, eligible;
   logic                accept, any_elig;
   logic [ID_W-1:0]     win_id;
   logic [DATA_W-1:0]   win_data;

   assign edge_v   = bus.irq_i & ~irq_q;
   assign accept   = (state_q == BUSY) & bus.ready_i;
   assign accept_v = accept ? ch_q : '0;
   assign eligible = pending_q & ~bus.mask_i;
   assign any_elig = |eligible;

   // A new edge always wins over the clear; it only counts as an overrun
   // when the channel stays pending through this cycle.
   assign pending_d = (pending_q & ~accept_v) | edge_v;
   assign overrun_d = overrun_q | (edge_v & pending_q & ~accept_v);

   // Later loop iterations override earlier ones, so the last index visited
   // is the highest priority: N_CH-1 in fixed mode, (last-1) mod N_CH in RR.
   always_comb begin
      int start;
      int idx;
      win_id   = '0;
      win_data = '0;
      start    = (int'(last_q) == 0) ? N_CH - 1 : int'(last_q) - 1;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (RR_MODE != 0) idx = (start + N_CH - i) % N_CH;
         else              idx = N_CH - 1 - i;
         if (eligible[ID_W'(idx)]) win_id = ID_W'(idx);
      end
      for (int k = 0; k < N_CH; k++) begin
         if (ID_W'(k) == win_id) win_data = bus.data_i[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_elig)    state_d = BUSY;
         BUSY:    if (bus.ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ch_d    = ch_q;
      id_d    = id_q;
      data_d  = data_q;
      multi_d = multi_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (any_elig) begin
               ch_d    = N_CH'(1) << win_id;
               id_d    = win_id;
               data_d  = win_data;
               multi_d = |(eligible & (eligible - N_CH'(1)));
               last_d  = win_id;
            end else begin
               ch_d    = '0;
               id_d    = '0;
               data_d  = '0;
               multi_d = 1'b0;
            end
         end
         BUSY: begin
            if (bus.ready_i) begin
               ch_d    = '0;
               id_d    = '0;
               data_d  = '0;
               multi_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_q     <= '0;
         pending_q <= '0;
         overrun_q <= '0;
         ch_q      <= '0;
         id_q      <= '0;
         data_q    <= '0;
         multi_q   <= 1'b0;
         last_q    <= '0;
      end else begin
         irq_q     <= bus.irq_i;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         ch_q      <= ch_d;
         id_q      <= id_d;
         data_q    <= data_d;
         multi_q   <= multi_d;
         last_q    <= last_d;
      end
   end

   assign bus.valid_o   = (state_q == BUSY);
   assign bus.ch_o      = ch_q;
   assign bus.id_o      = id_q;
   assign bus.data_o    = data_q;
   assign bus.multi_o   = multi_q;
   assign bus.pending_o = pending_q;
   assign bus.overrun_o = overrun_q;

endmodule
